mult_arbiter: RTL and testbench

MULT_ARBITER -- requirements
Module: mult_arbiter

---
 rtl/mult_pkg.sv | 22 ++
 rtl/mult_arbiter_multiplier.sv | 18 +
 rtl/mult_arbiter.sv | 135 +++++++++++++
 tb/tb_mult_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared constants and types for the two-requester multiplier arbiter.
//   DATA_W  : operand width
//   PROD_W  : full product width (2*DATA_W)
//   LATENCY : cycles from an accepted request to its response pulse
//   owner_e : owner tag carried down the pipeline (0 = req0, 1 = req1)
package mult_pkg;

   localparam int unsigned DATA_W  = 32;
   localparam int unsigned PROD_W  = 2 * DATA_W;
   localparam int unsigned LATENCY = 2;

   typedef enum logic {
      TagReq0 = 1'b0,
      TagReq1 = 1'b1
   } owner_e;

   // The requester that did not own the given tag.
   function automatic owner_e other_owner(input owner_e tag);
      return (tag == TagReq0) ? TagReq1 : TagReq0;
   endfunction

endpackage

// File: rtl/mult_arbiter_multiplier.sv
// Combinational unsigned multiplier shared by both requesters.
//   a, b    : unsigned operands, DATA_W bits
//   product : full unsigned product, PROD_W bits, no truncation
module MultiplierOperator
   import mult_pkg::*;
#(
   parameter int unsigned DATA_W = mult_pkg::DATA_W,
   parameter int unsigned PROD_W = 2 * DATA_W
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [PROD_W-1:0] product
);

   // Widen both operands first so the multiply is carried out at full width.
   assign product = PROD_W'(a) * PROD_W'(b);

endmodule

// File: rtl/mult_arbiter.sv
// Two-requester front end for a single shared multiplier.
// Round-robin arbitration grants at most one requester per cycle; accepted operands flow
// through a two-stage pipeline and return as a one-cycle pulse to the owning requester.
//   clk, rst                  : clock, synchronous active-high reset
//   reqN_valid / reqN_ready   : request handshake, transfer when both high
//   reqN_a, reqN_b            : unsigned operands
//   respN_valid / respN_data  : result pulse and held last product for requester N
//   busy                      : an operation is in stage 1 or stage 2
//   op_count                  : wrapping count of accepted operations
module mult_arbiter
   import mult_pkg::*;
#(
   parameter int unsigned DATA_W = mult_pkg::DATA_W,
   parameter int unsigned PROD_W = 2 * DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   input  logic              req1_valid,
   output logic              req0_ready,
   output logic              req1_ready,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   output logic              resp0_valid,
   output logic              resp1_valid,
   output logic [PROD_W-1:0] resp0_data,
   output logic [PROD_W-1:0] resp1_data,
   output logic              busy,
   output logic [15:0]       op_count
);

   // Arbitration state
   owner_e rr_last_q;

   // Stage 1: captured operands and owner
   logic              s1_valid_q;
   owner_e            s1_tag_q;
   logic [DATA_W-1:0] s1_a_q;
   logic [DATA_W-1:0] s1_b_q;

   // Stage 2: valid and owner; the product lands in the owner's response register
   logic              s2_valid_q;
   owner_e            s2_tag_q;
   logic [PROD_W-1:0] resp0_data_q;
   logic [PROD_W-1:0] resp1_data_q;

   logic [15:0]       op_count_q;

   // Grant / transfer
   logic              grant0;
   logic              grant1;
   logic              xfer;
   owner_e            grant_tag;
   logic [DATA_W-1:0] grant_a;
   logic [DATA_W-1:0] grant_b;

   logic [PROD_W-1:0] product;

   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (!rst) begin
         if (req0_valid && req1_valid) begin
            // Contention: the requester not served last wins.
            grant0 = (other_owner(rr_last_q) == TagReq0);
            grant1 = !grant0;
         end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
         end
      end
   end

   assign xfer      = grant0 | grant1;
   assign grant_tag = grant1 ? TagReq1 : TagReq0;
   assign grant_a   = grant1 ? req1_a : req0_a;
   assign grant_b   = grant1 ? req1_b : req0_b;

   assign req0_ready = grant0;
   assign req1_ready = grant1;

   MultiplierOperator #(
      .DATA_W (DATA_W),
      .PROD_W (PROD_W)
   ) u_mult (
      .a       (s1_a_q),
      .b       (s1_b_q),
      .product (product)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_last_q    <= TagReq1;
         s1_valid_q   <= 1'b0;
         s1_tag_q     <= TagReq0;
         s1_a_q       <= '0;
         s1_b_q       <= '0;
         s2_valid_q   <= 1'b0;
         s2_tag_q     <= TagReq0;
         resp0_data_q <= '0;
         resp1_data_q <= '0;
         op_count_q   <= '0;
      end else begin
         s1_valid_q <= xfer;
         if (xfer) begin
            s1_tag_q   <= grant_tag;
            s1_a_q     <= grant_a;
            s1_b_q     <= grant_b;
            rr_last_q  <= grant_tag;
            op_count_q <= op_count_q + 16'd1;
         end

         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            s2_tag_q <= s1_tag_q;
            // Only the owner's data register moves, so the other side keeps its last result.
            if (s1_tag_q == TagReq0) begin
               resp0_data_q <= product;
            end else begin
               resp1_data_q <= product;
            end
         end
      end
   end

   assign resp0_valid = s2_valid_q && (s2_tag_q == TagReq0);
   assign resp1_valid = s2_valid_q && (s2_tag_q == TagReq1);
   assign resp0_data  = resp0_data_q;
   assign resp1_data  = resp1_data_q;
   assign busy        = s1_valid_q | s2_valid_q;
   assign op_count    = op_count_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter: arbitration table, directed corner sequences,
// randomized traffic against a queue-based reference model, and the op_count wrap.
module tb_mult_arbiter;
   import mult_pkg::*;

   logic        clk;
   logic        rst;
   logic        req0_valid, req1_valid;
   logic        req0_ready, req1_ready;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic        resp0_valid, resp1_valid;
   logic [63:0] resp0_data, resp1_data;
   logic        busy;
   logic [15:0] op_count;

   mult_arbiter dut (
      .clk         (clk),
      .rst         (rst),
      .req0_valid  (req0_valid),
      .req1_valid  (req1_valid),
      .req0_ready  (req0_ready),
      .req1_ready  (req1_ready),
      .req0_a      (req0_a),
      .req0_b      (req0_b),
      .req1_a      (req1_a),
      .req1_b      (req1_b),
      .resp0_valid (resp0_valid),
      .resp1_valid (resp1_valid),
      .resp0_data  (resp0_data),
      .resp1_data  (resp1_data),
      .busy        (busy),
      .op_count    (op_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   typedef struct {
      bit          owner;
      logic [63:0] prod;
      int          due;
   } pend_t;

   pend_t       q[$];
   bit          m_last;
   logic [15:0] m_count;
   logic [63:0] m_data0, m_data1;
   int          cyc;

   // Observations from the latest step
   bit g_r0, g_r1;
   int g_resp_cnt;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // One clock cycle. Called just after a posedge; returns just after the next one.
   task automatic step(input bit rs, input bit v0, input logic [31:0] a0, input logic [31:0] b0,
                       input bit v1, input logic [31:0] a1, input logic [31:0] b1);
      bit          e_r0, e_r1, e_v0, e_v1, e_busy;
      pend_t       p;
      rst        = rs;
      req0_valid = v0;
      req0_a     = a0;
      req0_b     = b0;
      req1_valid = v1;
      req1_a     = a1;
      req1_b     = b1;
      #1;
      e_r0 = 1'b0;
      e_r1 = 1'b0;
      if (!rs) begin
         if (v0 && v1) begin
            if (m_last) e_r0 = 1'b1;
            else        e_r1 = 1'b1;
         end else begin
            e_r0 = v0;
            e_r1 = v1;
         end
      end
      g_r0 = req0_ready;
      g_r1 = req1_ready;
      chk("req0_ready", 64'(req0_ready), 64'(e_r0));
      chk("req1_ready", 64'(req1_ready), 64'(e_r1));

      e_busy = (q.size() > 0);
      e_v0   = 1'b0;
      e_v1   = 1'b0;
      if (q.size() > 0 && q[0].due == cyc) begin
         p = q.pop_front();
         if (p.owner) begin
            e_v1    = 1'b1;
            m_data1 = p.prod;
         end else begin
            e_v0    = 1'b1;
            m_data0 = p.prod;
         end
      end
      if (resp0_valid || resp1_valid) g_resp_cnt++;
      chk("resp0_valid", 64'(resp0_valid), 64'(e_v0));
      chk("resp1_valid", 64'(resp1_valid), 64'(e_v1));
      chk("resp0_data", resp0_data, m_data0);
      chk("resp1_data", resp1_data, m_data1);
      chk("busy", 64'(busy), 64'(e_busy));
      chk("op_count", 64'(op_count), 64'(m_count));

      if (rs) begin
         q.delete();
         m_count = '0;
         m_last  = 1'b1;
         m_data0 = '0;
         m_data1 = '0;
      end else if (e_r0 || e_r1) begin
         p.owner = e_r1;
         p.prod  = e_r1 ? (64'(a1) * 64'(b1)) : (64'(a0) * 64'(b0));
         p.due   = cyc + int'(LATENCY);
         q.push_back(p);
         m_count = m_count + 16'd1;
         m_last  = e_r1;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0);
   endtask

   task automatic do_reset();
      // Valids high while in reset: no grant may be given.
      step(1'b1, 1'b1, 32'd9, 32'd9, 1'b1, 32'd9, 32'd9);
   endtask

   typedef struct {
      bit          v0;
      bit          v1;
      bit          r0;
      bit          r1;
      logic [15:0] cnt;
   } vec_t;

   vec_t tbl[11];

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          exp_g[6];
      bit          rs, v0, v1;
      logic [31:0] a0, b0, a1, b1;

      tbl[0]  = '{1, 1, 1, 0, 16'd0};
      tbl[1]  = '{1, 1, 0, 1, 16'd1};
      tbl[2]  = '{0, 1, 0, 1, 16'd2};
      tbl[3]  = '{1, 0, 1, 0, 16'd3};
      tbl[4]  = '{0, 0, 0, 0, 16'd4};
      tbl[5]  = '{1, 1, 0, 1, 16'd4};
      tbl[6]  = '{1, 1, 1, 0, 16'd5};
      tbl[7]  = '{1, 0, 1, 0, 16'd6};
      tbl[8]  = '{1, 1, 0, 1, 16'd7};
      tbl[9]  = '{0, 1, 0, 1, 16'd8};
      tbl[10] = '{1, 1, 1, 0, 16'd9};

      cyc        = 0;
      g_resp_cnt = 0;
      rst        = 1'b1;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      req0_a     = '0;
      req0_b     = '0;
      req1_a     = '0;
      req1_b     = '0;
      @(posedge clk);
      @(posedge clk);
      #1;
      // Reset state, sampled with rst still high
      chk("rst_req0_ready", 64'(req0_ready), 64'd0);
      chk("rst_req1_ready", 64'(req1_ready), 64'd0);
      chk("rst_resp0_valid", 64'(resp0_valid), 64'd0);
      chk("rst_resp1_valid", 64'(resp1_valid), 64'd0);
      chk("rst_resp0_data", resp0_data, 64'd0);
      chk("rst_resp1_data", resp1_data, 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_op_count", 64'(op_count), 64'd0);
      q.delete();
      m_last  = 1'b1;
      m_count = '0;
      m_data0 = '0;
      m_data1 = '0;

      // Arbitration table
      for (int i = 0; i < 11; i++) begin
         chk("tbl_op_count", 64'(op_count), 64'(tbl[i].cnt));
         step(1'b0, tbl[i].v0, 32'(i + 1), 32'(i + 3), tbl[i].v1, 32'(i + 100), 32'(i + 7));
         chk("tbl_ready0", 64'(g_r0), 64'(tbl[i].r0));
         chk("tbl_ready1", 64'(g_r1), 64'(tbl[i].r1));
      end
      idle();
      idle();

      // Single request: 3*5 on req0
      do_reset();
      step(1'b0, 1'b1, 32'd3, 32'd5, 1'b0, 32'd0, 32'd0);
      chk("single_ready0", 64'(g_r0), 64'd1);
      idle();
      chk("single_resp0_valid", 64'(resp0_valid), 64'd1);
      chk("single_resp0_data", resp0_data, 64'd15);
      chk("single_resp1_valid", 64'(resp1_valid), 64'd0);
      idle();
      chk("single_resp0_pulse", 64'(resp0_valid), 64'd0);
      chk("single_resp0_hold", resp0_data, 64'd15);

      // Contention right after reset: req0 first, req1 held and served next
      do_reset();
      step(1'b0, 1'b1, 32'd2, 32'd7, 1'b1, 32'd4, 32'd4);
      chk("cont_ready0", 64'(g_r0), 64'd1);
      chk("cont_ready1_wait", 64'(g_r1), 64'd0);
      step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'd4, 32'd4);
      chk("cont_ready1", 64'(g_r1), 64'd1);
      chk("cont_resp0_valid", 64'(resp0_valid), 64'd1);
      chk("cont_resp0_data", resp0_data, 64'd14);
      idle();
      chk("cont_resp1_valid", 64'(resp1_valid), 64'd1);
      chk("cont_resp1_data", resp1_data, 64'd16);
      idle();

      // Sustained contention: alternating grants, one result per cycle
      do_reset();
      g_resp_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 1'b1, 32'(10 + i), 32'd3, 1'b1, 32'(20 + i), 32'd5);
         exp_g[i] = g_r1;
      end
      for (int i = 0; i < 6; i++) chk("alt_grant", 64'(exp_g[i]), 64'(i % 2));
      chk("alt_op_count", 64'(op_count), 64'd6);
      idle();
      idle();
      chk("alt_resp_count", 64'(g_resp_cnt), 64'd6);
      idle();

      // Max operands
      do_reset();
      step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      idle();
      chk("max_resp1_valid", 64'(resp1_valid), 64'd1);
      chk("max_resp1_data", resp1_data, 64'hFFFF_FFFE_0000_0001);
      idle();

      // Reset mid-operation drops the in-flight result
      do_reset();
      step(1'b0, 1'b1, 32'd6, 32'd6, 1'b0, 32'd0, 32'd0);
      step(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0);
      chk("midrst_resp0_valid", 64'(resp0_valid), 64'd0);
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_op_count", 64'(op_count), 64'd0);
      idle();
      chk("midrst_resp0_late", 64'(resp0_valid), 64'd0);

      // Randomized traffic against the model
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         rs = ($urandom_range(0, 149) == 0);
         v0 = ($urandom_range(0, 2) != 0);
         v1 = ($urandom_range(0, 2) != 0);
         a0 = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF : $urandom;
         b0 = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF : $urandom;
         a1 = ($urandom_range(0, 9) == 0) ? 32'd0 : $urandom;
         b1 = $urandom;
         step(rs, v0, a0, b0, v1, a1, b1);
      end
      idle();
      idle();

      // Counter wrap
      do_reset();
      for (int i = 0; i < 65536; i++) begin
         step(1'b0, 1'b1, 32'(i), 32'd3, 1'b0, 32'd0, 32'd0);
      end
      chk("wrap_op_count", 64'(op_count), 64'd0);
      idle();
      idle();
      chk("wrap_busy", 64'(busy), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
